// File: rtl/mul_result_queue.sv
// Carries issue tags alongside the multiplier, forms signed results and queues them for the CDB.
// Result visible STAGE+1 cycles after issue; issue_ready is withheld so queued + in-flight ops never exceed DEPTH.
module mul_result_queue #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5,
    parameter int STAGE   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 issue_valid,
    input  logic [1:0]           issue_func,
    input  logic                 issue_a_sign,
    input  logic                 issue_b_sign,
    input  logic [PRF_LEN-1:0]   issue_prf_idx,
    input  logic [ROB_LEN-1:0]   issue_rob_idx,
    input  logic [XLEN-1:0]      issue_pc,
    output logic                 issue_ready,
    input  logic                 prod_done,
    input  logic [2*XLEN-1:0]    product,
    output logic                 cdb_valid,
    output logic [XLEN-1:0]      cdb_value,
    output logic [PRF_LEN-1:0]   cdb_prf_idx,
    output logic [ROB_LEN-1:0]   cdb_rob_idx,
    output logic [XLEN-1:0]      cdb_pc,
    input  logic                 cdb_grant
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(STAGE + 1);
    localparam int SUM_W = $clog2(DEPTH + STAGE + 1);

    localparam logic [1:0] FUNC_MUL    = 2'b00;
    localparam logic [1:0] FUNC_MULH   = 2'b01;
    localparam logic [1:0] FUNC_MULHSU = 2'b10;

    typedef struct packed {
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
    } tag_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] func;
        logic       neg;
        tag_t       tag;
    } pipe_t;

    typedef struct packed {
        logic [XLEN-1:0] value;
        tag_t            tag;
    } ent_t;

    pipe_t              pipe_q [STAGE];
    pipe_t              issue_ent;
    pipe_t              exit_ent;
    ent_t               mem_q [DEPTH];
    ent_t               head_ent;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [INF_W-1:0]   inflight;
    logic [SUM_W-1:0]   credit_sum;
    logic               issue_neg;
    logic [2*XLEN-1:0]  full;
    logic [XLEN-1:0]    result;
    logic               push;
    logic               pop;

    // Sign of the final result is decided at issue so the product path stays unsigned.
    always_comb begin
        issue_neg = 1'b0;
        case (issue_func)
            FUNC_MUL, FUNC_MULH: issue_neg = issue_a_sign ^ issue_b_sign;
            FUNC_MULHSU:         issue_neg = issue_a_sign;
            default:             issue_neg = 1'b0;
        endcase
    end

    always_comb begin
        issue_ent             = '0;
        issue_ent.vld         = issue_valid;
        issue_ent.func        = issue_func;
        issue_ent.neg         = issue_neg;
        issue_ent.tag.prf_idx = issue_prf_idx;
        issue_ent.tag.rob_idx = issue_rob_idx;
        issue_ent.tag.pc      = issue_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGE; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= issue_ent;
            for (int i = 1; i < STAGE; i++) pipe_q[i] <= pipe_q[i-1];
            if (squash) begin
                for (int i = 0; i < STAGE; i++) pipe_q[i].vld <= 1'b0;
            end
        end
    end

    assign exit_ent = pipe_q[STAGE-1];
    assign full     = exit_ent.neg ? ((~product) + (2*XLEN)'(1)) : product;
    assign result   = (exit_ent.func == FUNC_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

    assign push      = exit_ent.vld && prod_done && !squash;
    assign cdb_valid = (count_q != '0);
    assign pop       = cdb_valid && cdb_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q].value <= result;
                mem_q[tail_q].tag   <= exit_ent.tag;
                tail_q              <= tail_q + PTR_W'(1);
            end
            if (pop) head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_ent    = mem_q[head_q];
    assign cdb_value   = cdb_valid ? head_ent.value       : '0;
    assign cdb_prf_idx = cdb_valid ? head_ent.tag.prf_idx : '0;
    assign cdb_rob_idx = cdb_valid ? head_ent.tag.rob_idx : '0;
    assign cdb_pc      = cdb_valid ? head_ent.tag.pc      : '0;

    // Credits count only registered state; a grant in the same cycle frees a slot one cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGE; i++) inflight = inflight + INF_W'(pipe_q[i].vld);
    end

    assign credit_sum  = SUM_W'(count_q) + SUM_W'(inflight);
    assign issue_ready = (credit_sum < SUM_W'(DEPTH));

    tag_done_aligned: assert property (@(posedge clock) disable iff (reset) exit_ent.vld |-> prod_done);
    no_push_at_full:  assert property (@(posedge clock) disable iff (reset) push |-> (count_q < CNT_W'(DEPTH)));

endmodule
